// File: rtl/fp_mul_seq_if.sv
// Request/response stream for the FP multiplier sequencer.
// Operand pair in, product and flags out, valid/ready both ways.
interface fp_mul_seq_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_res;
  logic        o_overflow;
  logic        o_underflow;

  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_res,
    input  o_overflow, o_underflow
  );

  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_res,
    output o_overflow, o_underflow
  );
endinterface

// File: rtl/fp_mul_seq.sv
// Sequencer for the serial Booth FP multiplier core: re-resets,
// loads and times the core, then buffers one result for downstream.
module fp_mul_seq #(
  parameter int RUN_CYCLES    = 25,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  fp_mul_seq_if.slave bus,
  output logic [31:0] o_core_a,
  output logic [31:0] o_core_b,
  output logic        o_core_load,
  output logic        o_core_rst,
  input  logic [31:0] i_core_res,
  input  logic        i_core_overflow,
  input  logic        i_core_underflow,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    RUN,
    SETTLE,
    WAIT
  } state_t;

  localparam logic [5:0] RUN_LAST = 6'(RUN_CYCLES - 1);
  localparam logic [5:0] SET_LAST = 6'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [5:0]  cnt;
  logic        load_q;
  logic        valid_q;
  logic [31:0] res_q;
  logic        ovf_q;
  logic        unf_q;
  logic        slot_free;

  assign slot_free = ~valid_q | bus.i_ready;

  assign bus.o_ready     = (state == IDLE) & ~i_rst;
  assign bus.o_valid     = valid_q;
  assign bus.o_res       = res_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = unf_q;

  assign o_core_rst  = i_rst | (state == CLR);
  assign o_core_load = load_q;
  assign o_busy      = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      load_q   <= 1'b0;
      valid_q  <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      o_core_a <= '0;
      o_core_b <= '0;
    end else begin
      // a capture below overrides this drain on the same edge
      if (valid_q & bus.i_ready) valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_valid) begin
            o_core_a <= bus.i_a;
            o_core_b <= bus.i_b;
            state    <= CLR;
          end
        end
        CLR: begin
          load_q <= 1'b1;
          state  <= LOAD;
        end
        LOAD: begin
          load_q <= 1'b0;
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: begin
          if (cnt == RUN_LAST) begin
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        SETTLE: begin
          if (cnt == SET_LAST) begin
            cnt <= '0;
            if (slot_free) begin
              res_q   <= i_core_res;
              ovf_q   <= i_core_overflow;
              unf_q   <= i_core_underflow;
              valid_q <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= WAIT;
            end
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        WAIT: begin
          if (slot_free) begin
            res_q   <= i_core_res;
            ovf_q   <= i_core_overflow;
            unf_q   <= i_core_underflow;
            valid_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq with a behavioural serial multiplier core
// that only presents a good product once the full run has elapsed.
module tb_fp_mul_seq;
  localparam int RC = 25;
  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_a, core_b, core_res;
  logic        core_load, core_rst, core_ovf, core_unf, busy;

  fp_mul_seq_if bus();

  fp_mul_seq #(.RUN_CYCLES(RC), .SETTLE_CYCLES(SC)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .bus              (bus),
    .o_core_a         (core_a),
    .o_core_b         (core_b),
    .o_core_load      (core_load),
    .o_core_rst       (core_rst),
    .i_core_res       (core_res),
    .i_core_overflow  (core_ovf),
    .i_core_underflow (core_unf),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // truncating single-precision multiply: {overflow, underflow, result}
  function automatic logic [33:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && b[30:0] == 0) || (eb == 255 && a[30:0] == 0))
      return {2'b00, 32'hFFFF_FFFF};
    if (ea == 255 || eb == 255) return {2'b00, s, 31'h7F80_0000};
    if (ea == 0 || eb == 0) return {2'b00, s, 31'h0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {2'b10, s, 31'h7F80_0000};
    if (e <= 0) return {2'b01, s, 31'h0};
    return {2'b00, s, e[7:0], m};
  endfunction

  // core model: garbage until RC+SC-1 edges after the load edge
  int   k;
  logic armed;
  always @(posedge clk) begin
    if (core_rst) begin
      armed    <= 1'b0;
      k        <= 0;
      core_res <= 32'hDEAD_BEEF;
      core_ovf <= 1'b1;
      core_unf <= 1'b1;
    end else if (core_load) begin
      armed    <= 1'b1;
      k        <= 0;
      core_res <= 32'hBADC_0DE5;
      core_ovf <= 1'b1;
      core_unf <= 1'b1;
    end else if (armed) begin
      k <= k + 1;
      if (k == RC + SC - 2) begin
        {core_ovf, core_unf, core_res} <= fmul(core_a, core_b);
        armed <= 1'b0;
      end
    end
  end

  logic        collect = 1'b0;
  logic [33:0] got_q[$];
  always @(posedge clk)
    if (collect && !rst && bus.o_valid && bus.i_ready)
      got_q.push_back({bus.o_overflow, bus.o_underflow, bus.o_res});

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] outv();
    return {bus.o_overflow, bus.o_underflow, bus.o_res};
  endfunction

  // one operation with downstream always ready, checking exact latency
  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [33:0] exp);
    int early;
    bus.i_ready = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_valid = 1'b1;
    chk({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    early = 0;
    for (int i = 0; i <= 28; i++) begin
      @(negedge clk);
      if (bus.o_valid || bus.o_ready || !busy ||
          core_a !== a || core_b !== b) early++;
      @(posedge clk);
    end
    @(negedge clk);
    chk({tag, "_window"}, 64'(early), 64'd0);
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'd1);
    chk({tag, "_res"}, 64'(outv()), 64'(exp));
    chk({tag, "_idle"}, 64'({bus.o_ready, busy}), 64'b10);
    @(negedge clk);
    chk({tag, "_drain"}, 64'(bus.o_valid), 64'd0);
  endtask

  logic [31:0] ra, rb;
  logic [33:0] exp_q[$];
  int          acc[8];
  int          n;

  initial begin
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.o_ready), 64'd0);
    chk("rst_core_rst", 64'(core_rst), 64'd1);
    chk("rst_out", 64'({bus.o_valid, outv()}), 64'd0);
    chk("rst_core_ops", {core_a, core_b}, 64'd0);
    chk("rst_busy_load", 64'({busy, core_load}), 64'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", 64'(bus.o_ready), 64'd1);

    run_op("basic", 32'h4040_0000, 32'h4000_0000, {2'b00, 32'h40C0_0000});
    run_op("inf_zero", 32'h7F80_0000, 32'h0, {2'b00, 32'hFFFF_FFFF});
    run_op("one_zero", 32'h3F80_0000, 32'h0, {2'b00, 32'h0});
    run_op("ovf", 32'h7F00_0000, 32'h7F00_0000, {2'b10, 32'h7F80_0000});

    // backpressure: 2*2 then 3*3 back-to-back
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_a     = 32'h4000_0000;
    bus.i_b     = 32'h4000_0000;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_a = 32'h4040_0000;
    bus.i_b = 32'h4040_0000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_valid && n < 40);
    chk("bp_latency", 64'(n), 64'd30);
    chk("bp_first", 64'(outv()), {30'd0, 34'h0_4080_0000});
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    repeat (36) @(negedge clk);
    chk("bp_wait", 64'({busy, bus.o_ready}), 64'b10);
    chk("bp_hold", 64'({bus.o_valid, outv()}), {29'd0, 1'b1, 34'h0_4080_0000});
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    chk("bp_replace", 64'({bus.o_valid, outv()}), {29'd0, 1'b1, 34'h0_4110_0000});
    chk("bp_idle", 64'({busy, bus.o_ready}), 64'b01);
    @(negedge clk);
    chk("bp_hold2", 64'({bus.o_valid, outv()}), {29'd0, 1'b1, 34'h0_4110_0000});
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain", 64'(bus.o_valid), 64'd0);

    // pending output dropped by reset
    bus.i_ready = 1'b0;
    bus.i_a     = 32'h3F80_0000;
    bus.i_b     = 32'h3F80_0000;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_valid && n < 40);
    chk("pend_valid", 64'(bus.o_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("pend_drop", 64'({bus.o_valid, outv()}), 64'd0);

    // reset on an accept edge wins
    @(negedge clk);
    bus.i_a     = 32'h1234_5678;
    bus.i_valid = 1'b1;
    rst         = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    #1 chk("rst_accept", 64'({busy, core_a}), 64'd0);

    // reset mid-RUN
    @(negedge clk);
    bus.i_ready = 1'b1;
    bus.i_a     = 32'h4049_0FDB;
    bus.i_b     = 32'h4049_0FDB;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rst_pins", 64'({core_rst, bus.o_ready}), 64'b10);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rst_ready", 64'({bus.o_ready, busy}), 64'b10);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_valid) n++;
    end
    chk("mid_rst_novalid", 64'(n), 64'd0);
    run_op("after_rst", 32'h3FC0_0000, 32'h3FC0_0000, {2'b00, 32'h4010_0000});

    // streaming random normal pairs
    collect     = 1'b1;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < 8; j++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)),
            23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)),
            23'($urandom)};
      exp_q.push_back(fmul(ra, rb));
      bus.i_a     = ra;
      bus.i_b     = rb;
      bus.i_valid = 1'b1;
      n = 0;
      while (!bus.o_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      acc[j] = cyc;
      #1;
    end
    bus.i_valid = 1'b0;
    repeat (35) @(negedge clk);
    collect = 1'b0;
    chk("stream_count", 64'(got_q.size()), 64'd8);
    for (int j = 1; j < 8; j++)
      chk($sformatf("stream_gap%0d", j), 64'(acc[j] - acc[j-1]), 64'd30);
    for (int j = 0; j < 8; j++)
      if (j < got_q.size())
        chk($sformatf("stream_res%0d", j), 64'(got_q[j]), 64'(exp_q[j]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Sequencing front-end for the single-precision floating-point multiplier core. It accepts operand pairs over a valid/ready handshake and drives the core's operand, load and reset pins. It waits out the core's serial Booth iterations, then captures the core's registered result and flags into an output register with its own valid/ready handshake. The core must be re-reset before every operation, so this block owns that sequencing; downstream logic only sees a clean request/response stream.

## Interface
- RUN_CYCLES, 25, core multiplier iteration count (>=1; core mantissa width + 1).
- SETTLE_CYCLES, 2, cycles after the last iteration before the core's registered result is valid (>=1).
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  reset: one clock, synchronous, active-high.
- i_valid  in  1  upstream operand pair valid.
- o_ready  out  1  block can accept an operand pair this cycle.
- i_a, i_b  in  32  IEEE-754 single operands.
- o_core_a, o_core_b  out  32  operands to the core, held stable for the whole operation.
- o_core_load  out  1  core load strobe.
- o_core_rst  out  1  core reset.
- i_core_res  in  32  core result.
- i_core_overflow, i_core_underflow  in  1  core flags.
- o_valid  out  1  result available.
- i_ready  in  1  downstream accepts result.
- o_res  out  32  product.
- o_overflow, o_underflow  out  1  flags captured with o_res.
- o_busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, CLR, LOAD, RUN, SETTLE, WAIT. One counter (6 bits) is shared by RUN and SETTLE.
- o_ready = (state==IDLE) & !i_rst.
- Accept occurs on an edge where i_valid & o_ready. At accept:
  - i_a/i_b are registered into o_core_a/o_core_b.
  - The state moves to CLR.
  - o_core_a/o_core_b change only on accept.
- CLR: o_core_rst=1 for one cycle, then LOAD.
- LOAD: o_core_load=1 for one cycle. Clear the counter and go to RUN.
- RUN: stay RUN_CYCLES cycles, counting up. On the last one, clear the counter and go to SETTLE.
- SETTLE: stay SETTLE_CYCLES cycles. At the end of the last cycle, check whether the slot is free (o_valid==0 | i_ready).
  - Slot free: capture i_core_res and both flags into o_res/o_overflow/o_underflow, set o_valid=1, go to IDLE.
  - Slot not free: go to WAIT.
- WAIT: the core holds its output because operands are stable and load is low. Capture on the first edge where the slot is free, then go to IDLE.
- Output handshake:
  - An edge with o_valid & i_ready and no capture clears o_valid.
  - An edge with both i_ready and a capture keeps o_valid=1 with the new data; no bubble, no loss.
  - o_res and the flags hold while o_valid & !i_ready.
- o_core_rst = i_rst | (state==CLR). o_core_load = (state==LOAD).
- Result ordering is strictly in acceptance order. There is at most one in flight plus one in the output register.
- No arithmetic is performed on operands or results; values pass through unmodified.

## Timing
- Reset values: state IDLE, counter 0, o_valid 0, o_res 0, o_overflow 0, o_underflow 0, o_core_a 0, o_core_b 0, o_core_load 0, o_busy 0. o_core_rst=1 and o_ready=0 while i_rst is high.
- Latency: if the accept is at edge t0, o_valid rises at edge t0+2+RUN_CYCLES+SETTLE_CYCLES (default t0+29), provided the slot is free.
- Earliest next accept is at edge t0+30. Sustained throughput is one op per 3+RUN_CYCLES+SETTLE_CYCLES cycles (default 30).
- i_valid while not IDLE is ignored; there is no accept.
- i_rst mid-operation (any state) aborts:
  - The in-flight op and any pending output are dropped.
  - o_valid drops at the reset edge.
  - o_ready is high in the first cycle after i_rst falls.
- i_rst on an accept edge: reset wins and no accept occurs.

## Test plan
- Basic: a=0x40400000, b=0x40000000, i_ready=1, accept at t0 -> o_valid at t0+29, o_res=0x40C00000, flags 0; o_ready low t0+1..t0+29.
- Special: a=0x7F800000, b=0x00000000 -> o_res=0xFFFFFFFF; a=0x3F800000, b=0x00000000 -> 0x00000000; flags 0.
- Overflow: a=b=0x7F000000 -> o_res=0x7F800000, o_overflow=1, o_underflow=0.
- Backpressure: i_ready=0, issue 2.0*2.0 then 3.0*3.0 back-to-back.
  - First result (0x40800000) held; the FSM sits in WAIT with o_ready=0.
  - Raise i_ready for one cycle -> 0x41100000 replaces it at that same edge with o_valid staying 1.
  - Then drain.
- Reset mid-RUN: assert i_rst at t0+10 for one cycle -> o_valid never rises for that op, o_core_rst high during reset, o_ready=1 next cycle; a following 1.5*1.5 (0x3FC00000) gives 0x40100000 correctly.
- Streaming: i_valid and i_ready held high, 8 random normal pairs -> accepts exactly every 30 cycles; results match the golden model in order.
